text_terminal_writer: RTL
=========================

// Module: text_terminal_writer
// PURPOSE
//  Terminal-style writer for the serial-LCD text buffer: accepts characters via valid/ready,
//  keeps a cursor, and emits one write per cycle to the text/fg/bg RAM write port.
//  Handles control chars, line wrap, screen overflow (wrap or clear) and a clear sequencer.
//  Sits between a character source (UART, demo counter, CPU) and ram_2port port 1.
// PARAMETERS
//  TEXT_COLS   20     characters per row
//  TEXT_ROWS   6      character rows
//  ADDR_BITS   8      write address width; must satisfy 2**ADDR_BITS >= TEXT_COLS*TEXT_ROWS
//  CHAR_BITS   8      character code width
//  PIXEL_BITS  16     colour word width (RGB565)
//  SCROLL_MODE 0      0: row overflow wraps to row 0; 1: row overflow clears screen, homes cursor
//  DEF_FG      'hffff fg colour written during clear
//  DEF_BG      'h001f bg colour written during clear
// PORTS
//  slow_clk       in   1           clock
//  rst            in   1           reset, asynchronous, active-high
//  in_char_valid  in   1           character present
//  in_char        in   CHAR_BITS   character code
//  out_char_ready out  1           char accepted on edge where valid & ready
//  in_fgcol       in   PIXEL_BITS  fg colour stored with printable chars
//  in_bgcol       in   PIXEL_BITS  bg colour stored with printable chars
//  in_clear       in   1           request full clear + home
//  out_wr_ena     out  1           RAM write strobe
//  out_wr_addr    out  ADDR_BITS   row*TEXT_COLS + col
//  out_wr_char    out  CHAR_BITS   char to write
//  out_wr_fgcol   out  PIXEL_BITS  fg colour to write
//  out_wr_bgcol   out  PIXEL_BITS  bg colour to write
//  out_cursor_x   out  $clog2(TEXT_COLS)  cursor column
//  out_cursor_y   out  $clog2(TEXT_ROWS)  cursor row
//  out_busy       out  1           high while in CLEAR
// BEHAVIOUR
//  - Reset: state=CLEAR, clear counter=0, cursor=(0,0), all wr_* outputs 0, ready 0, busy 1.
//  - States: CLEAR, IDLE. out_char_ready = (state==IDLE) & ~in_clear (combinational).
//  - CLEAR: each cycle registered write of 8'h20/DEF_FG/DEF_BG to addr=counter, counter+1;
//    after addr TEXT_COLS*TEXT_ROWS-1 -> IDLE, cursor=(0,0). No addr >= N is ever written.
//  - IDLE + in_clear -> CLEAR (counter=0); wins over simultaneous valid (char not accepted).
//  - Accepted char: all wr_* registered, valid the cycle after acceptance (latency 1); cursor
//    updates on the accepting edge. out_wr_ena is a single-cycle pulse per write.
//  - Printable (>=8'h20, !=8'h7f): write at cursor with in_fgcol/in_bgcol; col+1.
//  - 8'h0A LF: col=0,row+1, no write. 8'h0D CR: col=0, no write.
//  - 8'h08 BS: if col>0, col-1 and write space at new pos; at col 0 no-op (no write).
//  - 8'h0C FF: same as in_clear. Other codes <8'h20 and 8'h7f: accepted, ignored.
//  - Column overflow (col was TEXT_COLS-1 after print): col=0, row+1.
//  - Row overflow (row+1 == TEXT_ROWS): SCROLL_MODE 0 -> row=0; 1 -> enter CLEAR (busy next cycle).
//  - Address arithmetic in ADDR_BITS, no truncation for legal params; cursor never >= limits.
//  - Reset mid-CLEAR or mid-write: immediate return to reset state; clear restarts from 0.
// TESTING
//  - Reset, then idle: exactly 120 writes addr 0..119, char 8'h20, fg ffff, bg 001f; then ready=1, busy=0.
//  - Send "AB" with fg=f800: writes (0,'A',f800),(1,'B',f800) each 1 cycle after accept; cursor x=2.
//  - Print 21 chars from (0,0): 21st written at addr 20, cursor=(1,1).
//  - Cursor (19,5), SCROLL_MODE 0, print 'Z': write addr 119, cursor=(0,0); SCROLL_MODE 1: then 120 clear writes.
//  - Cursor (3,2): BS -> write space addr 42, cursor (2,2); CR -> (0,2), no write; BS at col 0 -> no write.
//  - in_clear and valid same cycle in IDLE: char not accepted, busy next cycle; rst asserted mid-clear restarts at addr 0.

Source files
------------

// File: rtl/text_terminal_writer_if.sv
// Character-source and RAM-write-port bundle for text_terminal_writer.
// The writer takes the slave side; the character source / RAM side takes the master side.
interface text_terminal_writer_if #(
   parameter int ADDR_BITS  = 8,
   parameter int CHAR_BITS  = 8,
   parameter int PIXEL_BITS = 16
);
   logic                  in_char_valid;
   logic [CHAR_BITS-1:0]  in_char;
   logic                  out_char_ready;
   logic [PIXEL_BITS-1:0] in_fgcol;
   logic [PIXEL_BITS-1:0] in_bgcol;
   logic                  in_clear;
   logic                  out_wr_ena;
   logic [ADDR_BITS-1:0]  out_wr_addr;
   logic [CHAR_BITS-1:0]  out_wr_char;
   logic [PIXEL_BITS-1:0] out_wr_fgcol;
   logic [PIXEL_BITS-1:0] out_wr_bgcol;

   modport master (
      output in_char_valid, in_char, in_fgcol, in_bgcol, in_clear,
      input  out_char_ready, out_wr_ena, out_wr_addr, out_wr_char, out_wr_fgcol, out_wr_bgcol
   );

   modport slave (
      input  in_char_valid, in_char, in_fgcol, in_bgcol, in_clear,
      output out_char_ready, out_wr_ena, out_wr_addr, out_wr_char, out_wr_fgcol, out_wr_bgcol
   );
endinterface

// File: rtl/text_terminal_writer.sv
// Terminal-style writer: turns a character stream into single-cycle writes to the
// text/fg/bg RAM, tracking a cursor and handling control codes, wrap and screen clear.
module text_terminal_writer #(
   parameter int TEXT_COLS   = 20,
   parameter int TEXT_ROWS   = 6,
   parameter int ADDR_BITS   = 8,
   parameter int CHAR_BITS   = 8,
   parameter int PIXEL_BITS  = 16,
   parameter int SCROLL_MODE = 0,
   parameter logic [PIXEL_BITS-1:0] DEF_FG = PIXEL_BITS'(16'hffff),
   parameter logic [PIXEL_BITS-1:0] DEF_BG = PIXEL_BITS'(16'h001f)
) (
   input  logic                         slow_clk,
   input  logic                         rst,
   text_terminal_writer_if.slave        bus,
   output logic [$clog2(TEXT_COLS)-1:0] out_cursor_x,
   output logic [$clog2(TEXT_ROWS)-1:0] out_cursor_y,
   output logic                         out_busy
);
   localparam int XW    = $clog2(TEXT_COLS);
   localparam int YW    = $clog2(TEXT_ROWS);
   localparam int CELLS = TEXT_COLS * TEXT_ROWS;

   localparam logic [ADDR_BITS-1:0] CNT_LAST = ADDR_BITS'(CELLS - 1);
   localparam logic [ADDR_BITS-1:0] COLS_A   = ADDR_BITS'(TEXT_COLS);
   localparam logic [XW-1:0]        X_LAST   = XW'(TEXT_COLS - 1);
   localparam logic [YW-1:0]        Y_LAST   = YW'(TEXT_ROWS - 1);

   localparam logic [CHAR_BITS-1:0] CH_SPACE = CHAR_BITS'(8'h20);
   localparam logic [CHAR_BITS-1:0] CH_DEL   = CHAR_BITS'(8'h7f);
   localparam logic [CHAR_BITS-1:0] CH_LF    = CHAR_BITS'(8'h0a);
   localparam logic [CHAR_BITS-1:0] CH_CR    = CHAR_BITS'(8'h0d);
   localparam logic [CHAR_BITS-1:0] CH_BS    = CHAR_BITS'(8'h08);
   localparam logic [CHAR_BITS-1:0] CH_FF    = CHAR_BITS'(8'h0c);

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

   state_t                state_r, state_nxt_s;
   logic [ADDR_BITS-1:0]  clr_cnt_r, clr_cnt_nxt_s;
   logic [XW-1:0]         cur_x_r, cur_x_nxt_s;
   logic [YW-1:0]         cur_y_r, cur_y_nxt_s;
   logic                  wr_ena_r, wr_ena_nxt_s;
   logic [ADDR_BITS-1:0]  wr_addr_r, wr_addr_nxt_s;
   logic [CHAR_BITS-1:0]  wr_char_r, wr_char_nxt_s;
   logic [PIXEL_BITS-1:0] wr_fg_r, wr_fg_nxt_s;
   logic [PIXEL_BITS-1:0] wr_bg_r, wr_bg_nxt_s;

   logic                  ready_s, accept_s;
   logic                  print_s, lf_s, cr_s, bs_s, ff_s;
   logic                  last_col_s, last_row_s, row_adv_s, scroll_clear_s;
   logic [ADDR_BITS-1:0]  cur_addr_s;

   assign ready_s  = (state_r == ST_IDLE) && !bus.in_clear;
   assign accept_s = bus.in_char_valid && ready_s;

   assign print_s = accept_s && (bus.in_char >= CH_SPACE) && (bus.in_char != CH_DEL);
   assign lf_s    = accept_s && (bus.in_char == CH_LF);
   assign cr_s    = accept_s && (bus.in_char == CH_CR);
   // Backspace at column 0 is a no-op, so it only counts when there is a column to step back to.
   assign bs_s    = accept_s && (bus.in_char == CH_BS) && (cur_x_r != XW'(0));
   assign ff_s    = accept_s && (bus.in_char == CH_FF);

   assign last_col_s     = (cur_x_r == X_LAST);
   assign last_row_s     = (cur_y_r == Y_LAST);
   assign row_adv_s      = (print_s && last_col_s) || lf_s;
   assign scroll_clear_s = row_adv_s && last_row_s && (SCROLL_MODE != 0);

   assign cur_addr_s = ADDR_BITS'(cur_y_r) * COLS_A + ADDR_BITS'(cur_x_r);

   assign bus.out_char_ready = ready_s;
   assign bus.out_wr_ena     = wr_ena_r;
   assign bus.out_wr_addr    = wr_addr_r;
   assign bus.out_wr_char    = wr_char_r;
   assign bus.out_wr_fgcol   = wr_fg_r;
   assign bus.out_wr_bgcol   = wr_bg_r;
   assign out_cursor_x       = cur_x_r;
   assign out_cursor_y       = cur_y_r;
   assign out_busy           = (state_r == ST_CLEAR);

   // State, cursor, clear counter and write-port registers.
   always_ff @(posedge slow_clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_CLEAR;
         clr_cnt_r <= '0;
         cur_x_r   <= '0;
         cur_y_r   <= '0;
         wr_ena_r  <= 1'b0;
         wr_addr_r <= '0;
         wr_char_r <= '0;
         wr_fg_r   <= '0;
         wr_bg_r   <= '0;
      end else begin
         state_r   <= state_nxt_s;
         clr_cnt_r <= clr_cnt_nxt_s;
         cur_x_r   <= cur_x_nxt_s;
         cur_y_r   <= cur_y_nxt_s;
         wr_ena_r  <= wr_ena_nxt_s;
         wr_addr_r <= wr_addr_nxt_s;
         wr_char_r <= wr_char_nxt_s;
         wr_fg_r   <= wr_fg_nxt_s;
         wr_bg_r   <= wr_bg_nxt_s;
      end
   end

   // Next-state decision: clear runs to the last cell; clear requests win over characters.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_CLEAR: begin
            if (clr_cnt_r == CNT_LAST) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_CLEAR;
            end
         end
         ST_IDLE: begin
            if (bus.in_clear || ff_s || scroll_clear_s) begin
               state_nxt_s = ST_CLEAR;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         default: state_nxt_s = ST_CLEAR;
      endcase
   end

   // Write-port, cursor and clear-counter next values.
   always_comb begin
      clr_cnt_nxt_s = clr_cnt_r;
      cur_x_nxt_s   = cur_x_r;
      cur_y_nxt_s   = cur_y_r;
      wr_ena_nxt_s  = 1'b0;
      wr_addr_nxt_s = wr_addr_r;
      wr_char_nxt_s = wr_char_r;
      wr_fg_nxt_s   = wr_fg_r;
      wr_bg_nxt_s   = wr_bg_r;
      case (state_r)
         ST_CLEAR: begin
            wr_ena_nxt_s  = 1'b1;
            wr_addr_nxt_s = clr_cnt_r;
            wr_char_nxt_s = CH_SPACE;
            wr_fg_nxt_s   = DEF_FG;
            wr_bg_nxt_s   = DEF_BG;
            if (clr_cnt_r == CNT_LAST) begin
               clr_cnt_nxt_s = '0;
               cur_x_nxt_s   = '0;
               cur_y_nxt_s   = '0;
            end else begin
               clr_cnt_nxt_s = clr_cnt_r + ADDR_BITS'(1);
            end
         end
         ST_IDLE: begin
            if (print_s) begin
               wr_ena_nxt_s  = 1'b1;
               wr_addr_nxt_s = cur_addr_s;
               wr_char_nxt_s = bus.in_char;
               wr_fg_nxt_s   = bus.in_fgcol;
               wr_bg_nxt_s   = bus.in_bgcol;
            end else if (bs_s) begin
               wr_ena_nxt_s  = 1'b1;
               wr_addr_nxt_s = cur_addr_s - ADDR_BITS'(1);
               wr_char_nxt_s = CH_SPACE;
               wr_fg_nxt_s   = bus.in_fgcol;
               wr_bg_nxt_s   = bus.in_bgcol;
            end else begin
               wr_ena_nxt_s  = 1'b0;
            end
            // A print into the last cell in clear mode still writes before the clear starts.
            if (bus.in_clear || ff_s || scroll_clear_s) begin
               clr_cnt_nxt_s = '0;
               cur_x_nxt_s   = '0;
               cur_y_nxt_s   = '0;
            end else if (row_adv_s) begin
               cur_x_nxt_s = '0;
               cur_y_nxt_s = last_row_s ? YW'(0) : cur_y_r + YW'(1);
            end else if (print_s) begin
               cur_x_nxt_s = cur_x_r + XW'(1);
            end else if (cr_s) begin
               cur_x_nxt_s = '0;
            end else if (bs_s) begin
               cur_x_nxt_s = cur_x_r - XW'(1);
            end else begin
               cur_x_nxt_s = cur_x_r;
            end
         end
         default: begin
            clr_cnt_nxt_s = '0;
            cur_x_nxt_s   = '0;
            cur_y_nxt_s   = '0;
         end
      endcase
   end
endmodule
